casex_rr_arbiter: RTL and testbench

- Four-requester arbiter sharing one downstream resource, e.g. a single `casex`-decoded output register.
- Priority selection is a `casex` wildcard priority encoder (`4'b???1`, `4'b??10`, ...).
- The surrounding FSM adds registered one-hot grants, grant hold, round-robin rotation and hold-limit preemption.
- Sits between request sources and the shared decoder/datapath; its grant steers the datapath mux.

---
 rtl/casex_rr_arbiter_pkg.sv | 27 ++
 rtl/casex_rr_arbiter_prio_enc4.sv | 30 +++
 rtl/casex_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_casex_rr_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/casex_rr_arbiter_pkg.sv
// Shared types and constants for the four-way casex arbiter.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package casex_arb_pkg;

  // Number of requesters served by one arbiter.
  localparam int NREQ = 4;

  // Values accepted by the PRIO_MODE parameter of casex_rr_arbiter.
  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // Arbiter control state.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Rotate a request vector right by sh positions, so that bit i of the
  // result is bit (i+sh) mod NREQ of the input. After rotation the encoder's
  // bit 0 is the requester that sits just after the last owner.
  function automatic logic [NREQ-1:0] rotr4(input logic [NREQ-1:0] v,
                                            input logic [1:0]      sh);
    return NREQ'({v, v} >> sh);
  endfunction

endpackage

// File: rtl/casex_rr_arbiter_prio_enc4.sv
// Four-input priority encoder built on a casex wildcard table; bit 0 wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result follows req_vec directly.
//
// Ports:
//   req_vec  in  [3:0]  candidate request vector
//   idx      out [1:0]  index of the winning bit (0 when hit=0)
//   hit      out        at least one bit of req_vec is set
module prio_enc4 (
  input  logic [3:0] req_vec,
  output logic [1:0] idx,
  output logic       hit
);

  // The ? positions are don't-care, so the first arm that matches is the
  // lowest set bit. X/Z on req_vec would also match a ?, which is why the
  // top level asserts that req is always known.
  always_comb begin
    idx = 2'd0;
    hit = 1'b0;
    casex (req_vec)
      4'b???1: begin idx = 2'd0; hit = 1'b1; end
      4'b??10: begin idx = 2'd1; hit = 1'b1; end
      4'b?100: begin idx = 2'd2; hit = 1'b1; end
      4'b1000: begin idx = 2'd3; hit = 1'b1; end
      default: begin idx = 2'd0; hit = 1'b0; end
    endcase
  end

endmodule

// File: rtl/casex_rr_arbiter.sv
// Four-requester arbiter with registered one-hot grant, hold and preemption.
// Latency: req sampled at edge t, gnt visible after that edge (one register).
// Backpressure: requesters hold req until served; owner keeps gnt while req
//   stays high, unless the hold limit expires with another requester waiting.
//
// Ports:
//   clk      in         rising-edge clock
//   rst_n    in         asynchronous active-low reset
//   req      in  [3:0]  level request per requester
//   gnt      out [3:0]  registered one-hot grant, or 0
//   gnt_id   out [1:0]  index of the current owner (valid with gnt_vld)
//   gnt_vld  out        gnt is nonzero
//   preempt  out        one-cycle pulse when the hold limit takes a grant away
module casex_rr_arbiter
  import casex_arb_pkg::*;
#(
  parameter int PRIO_MODE = 1,   // 0: fixed, req[0] highest; 1: round-robin
  parameter int MAX_HOLD  = 8,   // 2..255 consecutive cycles under contention
  parameter int CNT_W     = 8    // 2**CNT_W must exceed MAX_HOLD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      gnt_id,
  output logic            gnt_vld,
  output logic            preempt
);

  // Last cycle an owner may hold the grant while someone else waits.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e      state_q, state_d;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic [1:0]      last_ptr, last_ptr_d;
  logic [NREQ-1:0] gnt_d;
  logic [1:0]      gnt_id_d;
  logic            gnt_vld_d;
  logic            preempt_d;

  // Candidate selection
  logic [NREQ-1:0] pending;     // requests other than the current owner
  logic            owner_req;   // current owner still requesting
  logic            at_limit;
  logic [1:0]      rr_shift;
  logic [NREQ-1:0] enc_in;
  logic [1:0]      enc_idx;
  logic            enc_hit;
  logic [1:0]      sel_id;

  // Masking with the registered grant serves all three selection cases:
  // in IDLE gnt is 0, on a release the owner's req is already low, and on a
  // preemption it removes the owner from the competition.
  assign pending   = req & ~gnt;
  assign owner_req = |(req & gnt);
  assign at_limit  = (hold_cnt == HOLD_LAST);
  assign rr_shift  = last_ptr + 2'd1;

  always_comb begin
    if (PRIO_MODE == PRIO_RR) begin
      enc_in = rotr4(pending, rr_shift);
    end else begin
      enc_in = pending;
    end
  end

  prio_enc4 u_prio_enc4 (
    .req_vec (enc_in),
    .idx     (enc_idx),
    .hit     (enc_hit)
  );

  // Undo the rotation: the encoder's index is relative to last_ptr+1.
  always_comb begin
    if (PRIO_MODE == PRIO_RR) begin
      sel_id = enc_idx + rr_shift;
    end else begin
      sel_id = enc_idx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    logic take;

    state_d    = state_q;
    gnt_d      = gnt;
    gnt_id_d   = gnt_id;
    gnt_vld_d  = gnt_vld;
    preempt_d  = 1'b0;
    hold_cnt_d = hold_cnt;
    last_ptr_d = last_ptr;
    take       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enc_hit) begin
          take = 1'b1;
        end
      end

      GRANT: begin
        if (!owner_req) begin
          // Release. A release wins over the hold limit, so no preempt here.
          if (enc_hit) begin
            take = 1'b1;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            gnt_vld_d  = 1'b0;
            hold_cnt_d = '0;
          end
        end else if (at_limit && enc_hit) begin
          take      = 1'b1;
          preempt_d = 1'b1;
        end else if (!at_limit) begin
          hold_cnt_d = hold_cnt + CNT_W'(1);
        end
        // Otherwise the counter sits at HOLD_LAST and the uncontested owner
        // keeps the grant; preemption fires as soon as anyone else asks.
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (take) begin
      state_d    = GRANT;
      gnt_d      = 4'b0001 << sel_id;
      gnt_id_d   = sel_id;
      gnt_vld_d  = 1'b1;
      hold_cnt_d = '0;
      last_ptr_d = sel_id;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt      <= '0;
      gnt_id   <= 2'd0;
      gnt_vld  <= 1'b0;
      preempt  <= 1'b0;
      hold_cnt <= '0;
      last_ptr <= 2'd3;   // first round-robin pick starts at req[0]
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      gnt_id   <= gnt_id_d;
      gnt_vld  <= gnt_vld_d;
      preempt  <= preempt_d;
      hold_cnt <= hold_cnt_d;
      last_ptr <= last_ptr_d;
    end
  end

  // casex treats X/Z on req as wildcards and would grant silently.
  req_known_a: assert property (@(posedge clk) disable iff (!rst_n)
                                !$isunknown(req));

endmodule

// File: tb/tb_casex_rr_arbiter.sv
module tb_casex_rr_arbiter;

  logic       clk;
  logic       rst_n;

  logic [3:0] req_f, gnt_f;
  logic [1:0] gnt_id_f;
  logic       gnt_vld_f, preempt_f;

  logic [3:0] req_r, gnt_r;
  logic [1:0] gnt_id_r;
  logic       gnt_vld_r, preempt_r;

  int n_run  = 0;
  int n_fail = 0;

  casex_rr_arbiter #(.PRIO_MODE(0), .MAX_HOLD(8), .CNT_W(8)) u_fix (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_f),
    .gnt     (gnt_f),
    .gnt_id  (gnt_id_f),
    .gnt_vld (gnt_vld_f),
    .preempt (preempt_f)
  );

  casex_rr_arbiter #(.PRIO_MODE(1), .MAX_HOLD(8), .CNT_W(8)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_r),
    .gnt     (gnt_r),
    .gnt_id  (gnt_id_r),
    .gnt_vld (gnt_vld_r),
    .preempt (preempt_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 unit after an edge; returns 1 unit after the following edge.
  task automatic do_reset();
    rst_n = 1'b0;
    req_f = 4'b0000;
    req_r = 4'b0000;
    #4;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req_f = 4'b0000;
    req_r = 4'b0000;
    #12;
    chk("rst_gnt",     32'(gnt_r),     32'h0);
    chk("rst_gnt_vld", 32'(gnt_vld_r), 32'h0);
    chk("rst_gnt_id",  32'(gnt_id_r),  32'h0);
    chk("rst_preempt", 32'(preempt_r), 32'h0);
    chk("rst_gnt_fix", 32'(gnt_f),     32'h0);
    rst_n = 1'b1;
    tick();

    // Idle with no requests
    tick();
    chk("idle_gnt", 32'(gnt_r), 32'h0);

    // Reset in the middle of a grant
    req_r = 4'b0100;
    tick();
    chk("pre_rst_gnt", 32'(gnt_r), 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt_r),     32'h0);
    chk("async_rst_vld", 32'(gnt_vld_r), 32'h0);
    #1;
    rst_n = 1'b1;
    chk("post_rst_still0", 32'(gnt_r), 32'h0);
    tick();
    chk("post_rst_gnt",    32'(gnt_r),     32'h4);
    chk("post_rst_gnt_id", 32'(gnt_id_r),  32'h2);
    chk("post_rst_vld",    32'(gnt_vld_r), 32'h1);

    // Fixed priority
    do_reset();
    req_f = 4'b1110;
    chk("fix_latency", 32'(gnt_f), 32'h0);
    tick();
    chk("fix_gnt_1110", 32'(gnt_f),    32'h2);
    chk("fix_id_1110",  32'(gnt_id_f), 32'h1);
    req_f = 4'b1100;
    tick();
    chk("fix_handover_gnt", 32'(gnt_f),     32'h4);
    chk("fix_handover_vld", 32'(gnt_vld_f), 32'h1);
    req_f = 4'b1000;
    tick();
    chk("fix_next_gnt", 32'(gnt_f), 32'h8);
    req_f = 4'b0000;
    tick();
    chk("fix_idle_gnt", 32'(gnt_f),     32'h0);
    chk("fix_idle_vld", 32'(gnt_vld_f), 32'h0);

    // Round-robin: each owner drops its req for one cycle after its grant
    do_reset();
    req_r = 4'b1111;
    tick();
    chk("rr_id_0", 32'(gnt_id_r), 32'h0);
    chk("rr_gnt_0", 32'(gnt_r), 32'h1);
    req_r = 4'b1110;
    tick();
    chk("rr_id_1", 32'(gnt_id_r), 32'h1);
    req_r = 4'b1101;
    tick();
    chk("rr_id_2", 32'(gnt_id_r), 32'h2);
    req_r = 4'b1011;
    tick();
    chk("rr_id_3", 32'(gnt_id_r), 32'h3);
    req_r = 4'b0111;
    tick();
    chk("rr_id_0b", 32'(gnt_id_r), 32'h0);
    chk("rr_gnt_0b", 32'(gnt_r), 32'h1);
    req_r = 4'b0000;
    tick();
    chk("rr_idle_vld", 32'(gnt_vld_r), 32'h0);

    // Hold limit: req[0] continuous, req[3] joins at grant cycle 2
    do_reset();
    req_r = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("hold_gnt_c%0d", k), 32'(gnt_r),     32'h1);
      chk($sformatf("hold_pre_c%0d", k), 32'(preempt_r), 32'h0);
      if (k == 2) req_r = 4'b1001;
    end
    tick();
    chk("preempt_gnt",   32'(gnt_r),     32'h8);
    chk("preempt_pulse", 32'(preempt_r), 32'h1);
    chk("preempt_id",    32'(gnt_id_r),  32'h3);
    tick();
    chk("preempt_one_cycle", 32'(preempt_r), 32'h0);
    chk("preempt_new_hold",  32'(gnt_r),     32'h8);

    // No contention: owner keeps the grant past the hold limit
    do_reset();
    req_r = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("solo_gnt_c%0d", k), 32'(gnt_r),     32'h1);
      chk($sformatf("solo_pre_c%0d", k), 32'(preempt_r), 32'h0);
    end

    // Owner release coincides with the hold limit
    do_reset();
    req_r = 4'b0110;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("sim_gnt_c%0d", k), 32'(gnt_r), 32'h2);
      if (k == 8) req_r = 4'b0100;
    end
    tick();
    chk("sim_gnt",     32'(gnt_r),     32'h4);
    chk("sim_preempt", 32'(preempt_r), 32'h0);
    chk("sim_id",      32'(gnt_id_r),  32'h2);

    req_r = 4'b0000;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
